// File: rtl/ili_cmd_sequencer_if.sv
// Byte/pixel side of the ILI9341 command sequencer: init/stream controls,
// RGB565 pixel handshake (transfer = pix_valid & pix_ready) and the SPI byte port.
interface ili_cmd_sequencer_if;
    logic        init_req;
    logic        stream_start;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_ready;
    logic        spi_idle;
    logic [7:0]  tx_byte;
    logic        tx_dc;
    logic        tx_send;
    logic        rst_ili;
    logic        busy;
    logic        init_done;

    modport slave (
        input  init_req, stream_start, pix_valid, pix_data, spi_idle,
        output pix_ready, tx_byte, tx_dc, tx_send, rst_ili, busy, init_done
    );

    modport master (
        output init_req, stream_start, pix_valid, pix_data, spi_idle,
        input  pix_ready, tx_byte, tx_dc, tx_send, rst_ili, busy, init_done
    );
endinterface

// File: rtl/ili_cmd_sequencer.sv
// ILI9341 command/data byte source: panel hardware reset, fixed init table,
// then RAMWR plus RGB565 pixel streaming to an SPI byte master.
module ili_cmd_sequencer #(
    parameter int RST_LOW_CYC  = 16,
    parameter int RST_WAIT_CYC = 64,
    parameter int DELAY_UNIT   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    ili_cmd_sequencer_if.slave   bus,
    output logic [3:0]           dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RST_LO    = 4'd1,
        S_RST_WAIT  = 4'd2,
        S_FETCH     = 4'd3,
        S_ISSUE     = 4'd4,
        S_WAIT_ACK  = 4'd5,
        S_WAIT_DONE = 4'd6,
        S_DELAY     = 4'd7,
        S_READY     = 4'd8
    } state_e;

    // What the byte currently in flight belongs to; decides where WAIT_DONE goes.
    typedef enum logic [1:0] {
        CTX_INIT   = 2'd0,
        CTX_RAMWR  = 2'd1,
        CTX_PIX_HI = 2'd2,
        CTX_PIX_LO = 2'd3
    } ctx_e;

    localparam logic [1:0] T_CMD  = 2'b00;
    localparam logic [1:0] T_DATA = 2'b01;
    localparam logic [1:0] T_DLY  = 2'b10;
    localparam logic [1:0] T_END  = 2'b11;

    localparam int DLY_MAX = 255 * DELAY_UNIT;
    localparam int CNT_MAX = (DLY_MAX > RST_WAIT_CYC) ?
                             ((DLY_MAX > RST_LOW_CYC) ? DLY_MAX : RST_LOW_CYC) :
                             ((RST_WAIT_CYC > RST_LOW_CYC) ? RST_WAIT_CYC : RST_LOW_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LOW_LAST  = CNT_W'(RST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] RST_WAIT_LAST = CNT_W'(RST_WAIT_CYC - 1);
    localparam logic [7:0]       CMD_RAMWR     = 8'h2C;

    function automatic logic [9:0] init_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    return {T_CMD,  8'h01};
            4'd1:    return {T_DLY,  8'd5};
            4'd2:    return {T_CMD,  8'h11};
            4'd3:    return {T_DLY,  8'd120};
            4'd4:    return {T_CMD,  8'h3A};
            4'd5:    return {T_DATA, 8'h55};
            4'd6:    return {T_CMD,  8'h36};
            4'd7:    return {T_DATA, 8'h48};
            4'd8:    return {T_CMD,  8'h29};
            4'd9:    return {T_DLY,  8'd10};
            default: return {T_END,  8'h00};
        endcase
    endfunction

    state_e           state_q, state_d;
    ctx_e             ctx_q, ctx_d;
    logic [3:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       pend_byte_q, pend_byte_d;
    logic             pend_dc_q, pend_dc_d;
    logic [7:0]       pix_lo_q, pix_lo_d;
    logic             stream_open_q, stream_open_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             tx_dc_q, tx_dc_d;
    logic             tx_send_q, tx_send_d;
    logic             rst_ili_q, rst_ili_d;
    logic             init_done_q, init_done_d;
    logic             pix_ready_d;

    logic [9:0]       entry;
    logic [1:0]       entry_type;
    logic [7:0]       entry_val;
    logic [CNT_W-1:0] dly_load;

    assign entry      = init_entry(idx_q);
    assign entry_type = entry[9:8];
    assign entry_val  = entry[7:0];
    assign dly_load   = CNT_W'(32'(entry_val) * 32'(DELAY_UNIT));

    always_comb begin
        state_d       = state_q;
        ctx_d         = ctx_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        pend_byte_d   = pend_byte_q;
        pend_dc_d     = pend_dc_q;
        pix_lo_d      = pix_lo_q;
        stream_open_d = stream_open_q;
        tx_byte_d     = tx_byte_q;
        tx_dc_d       = tx_dc_q;
        tx_send_d     = 1'b0;
        rst_ili_d     = rst_ili_q;
        init_done_d   = init_done_q;
        pix_ready_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.init_req) begin
                    state_d       = S_RST_LO;
                    rst_ili_d     = 1'b0;
                    init_done_d   = 1'b0;
                    cnt_d         = '0;
                    idx_d         = '0;
                    stream_open_d = 1'b0;
                end
            end
            S_RST_LO: begin
                if (cnt_q == RST_LOW_LAST) begin
                    state_d   = S_RST_WAIT;
                    rst_ili_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RST_WAIT: begin
                if (cnt_q == RST_WAIT_LAST) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FETCH: begin
                case (entry_type)
                    T_CMD, T_DATA: begin
                        pend_byte_d = entry_val;
                        pend_dc_d   = (entry_type == T_DATA);
                        ctx_d       = CTX_INIT;
                        state_d     = S_ISSUE;
                    end
                    T_DLY: begin
                        cnt_d   = dly_load;
                        state_d = S_DELAY;
                    end
                    default: begin
                        state_d     = S_READY;
                        init_done_d = 1'b1;
                    end
                endcase
            end
            S_ISSUE: begin
                if (bus.spi_idle) begin
                    tx_byte_d = pend_byte_q;
                    tx_dc_d   = pend_dc_q;
                    tx_send_d = 1'b1;
                    state_d   = S_WAIT_ACK;
                end
            end
            // The master needs a cycle to drop spi_idle; waiting for that avoids
            // mistaking the pre-send idle level for completion.
            S_WAIT_ACK: begin
                if (!bus.spi_idle) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.spi_idle) begin
                    case (ctx_q)
                        CTX_INIT: begin
                            idx_d   = idx_q + 4'd1;
                            state_d = S_FETCH;
                        end
                        CTX_RAMWR: begin
                            stream_open_d = 1'b1;
                            state_d       = S_READY;
                        end
                        CTX_PIX_HI: begin
                            pend_byte_d = pix_lo_q;
                            pend_dc_d   = 1'b1;
                            ctx_d       = CTX_PIX_LO;
                            state_d     = S_ISSUE;
                        end
                        default: state_d = S_READY;
                    endcase
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_READY: begin
                if (bus.init_req) begin
                    state_d       = S_RST_LO;
                    rst_ili_d     = 1'b0;
                    init_done_d   = 1'b0;
                    cnt_d         = '0;
                    idx_d         = '0;
                    stream_open_d = 1'b0;
                end else if (bus.stream_start) begin
                    pend_byte_d = CMD_RAMWR;
                    pend_dc_d   = 1'b0;
                    ctx_d       = CTX_RAMWR;
                    state_d     = S_ISSUE;
                end else if (stream_open_q && bus.pix_valid) begin
                    pix_ready_d = 1'b1;
                    pend_byte_d = bus.pix_data[15:8];
                    pix_lo_d    = bus.pix_data[7:0];
                    pend_dc_d   = 1'b1;
                    ctx_d       = CTX_PIX_HI;
                    state_d     = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ctx_q         <= CTX_INIT;
            idx_q         <= '0;
            cnt_q         <= '0;
            pend_byte_q   <= '0;
            pend_dc_q     <= 1'b0;
            pix_lo_q      <= '0;
            stream_open_q <= 1'b0;
            tx_byte_q     <= '0;
            tx_dc_q       <= 1'b0;
            tx_send_q     <= 1'b0;
            rst_ili_q     <= 1'b1;
            init_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ctx_q         <= ctx_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            pend_byte_q   <= pend_byte_d;
            pend_dc_q     <= pend_dc_d;
            pix_lo_q      <= pix_lo_d;
            stream_open_q <= stream_open_d;
            tx_byte_q     <= tx_byte_d;
            tx_dc_q       <= tx_dc_d;
            tx_send_q     <= tx_send_d;
            rst_ili_q     <= rst_ili_d;
            init_done_q   <= init_done_d;
        end
    end

    assign bus.tx_byte   = tx_byte_q;
    assign bus.tx_dc     = tx_dc_q;
    assign bus.tx_send   = tx_send_q;
    assign bus.rst_ili   = rst_ili_q;
    assign bus.init_done = init_done_q;
    assign bus.pix_ready = pix_ready_d;
    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_READY);
    assign dbg_state     = state_q;

endmodule

// File: doc/ili_cmd_sequencer.md
Name: ili_cmd_sequencer

Overview:
- Command/data byte source that sits directly upstream of the SPI master (spi_ctrl + spi_shift path) in the ILI9341 display design.
- On request, it pulses the panel hardware reset and then walks a fixed internal init table of commands, parameters and delays.
- After init, it streams 16-bit RGB565 pixels as RAMWR data.
- Each byte goes to the SPI master with a D/C flag and a one-cycle send strobe, and the block waits for the master to finish before issuing the next byte.

Parameters:
RST_LOW_CYC, 16, cycles rst_ili is held low
RST_WAIT_CYC, 64, cycles waited after rst_ili released before first byte
DELAY_UNIT, 32, clock cycles per init-table delay unit

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
init_req  in  1  pulse; starts hardware reset + init sequence
stream_start  in  1  pulse; sends RAMWR (0x2C) command, opens pixel stream
pix_valid  in  1  pixel available
pix_data  in  16  RGB565 pixel, sent MSB byte first
pix_ready  out  1  pixel accepted this cycle (pix_valid & pix_ready = transfer)
spi_idle  in  1  SPI master idle/done flag, high when no transfer in progress
tx_byte  out  8  byte presented to SPI master, stable from tx_send until done
tx_dc  out  1  0 = command, 1 = data; stable with tx_byte
tx_send  out  1  one-cycle strobe requesting transmission of tx_byte
rst_ili  out  1  panel reset, active low
busy  out  1  high in any state except IDLE and READY
init_done  out  1  high once init table completes; cleared by rst or new init_req

Behaviour:
Reset values:
- tx_byte=0x00, tx_dc=0, tx_send=0, pix_ready=0, rst_ili=1, busy=0, init_done=0.
- FSM=IDLE, table index=0, counters=0.
- Reset mid-operation aborts immediately with no further tx_send.

Init table: 4-bit index, entry = {type[1:0], val[7:0]}; type 00 cmd, 01 data, 10 delay, 11 end.
- Contents by index: 0 cmd 0x01; 1 dly 5; 2 cmd 0x11; 3 dly 120; 4 cmd 0x3A; 5 data 0x55; 6 cmd 0x36; 7 data 0x48; 8 cmd 0x29; 9 dly 10; 10 end.

FSM states:
- IDLE: init_req -> RST_LO (rst_ili=0, init_done=0, counter cleared). stream_start and pix_valid are ignored.
- RST_LO: after RST_LOW_CYC cycles -> RST_WAIT (rst_ili=1).
- RST_WAIT: after RST_WAIT_CYC cycles -> FETCH with index=0.
- FETCH: decode entry[index].
  - cmd/data -> ISSUE.
  - dly -> DELAY, loading val*DELAY_UNIT.
  - end -> READY and set init_done.
- ISSUE: wait until spi_idle=1, then drive tx_byte/tx_dc and a tx_send pulse for exactly one cycle -> WAIT_ACK.
- WAIT_ACK: wait for spi_idle=0 (transfer accepted) -> WAIT_DONE.
- WAIT_DONE: wait for spi_idle=1.
  - If in init: index+1 -> FETCH.
  - If in the pixel path: go to the next pixel substate.
- DELAY: count down to 0 -> FETCH with index+1. A delay of 0 advances on the next cycle.
- READY: stream_start -> RAMWR issue (cmd 0x2C, dc=0), then back to READY with stream_open=1.
  - With stream_open=1 and pix_valid: pix_ready=1 for one cycle, latch pix_data, send hi byte (dc=1), then lo byte (dc=1), then back to READY.
  - pix_valid without stream_open: pix_ready stays 0.
  - init_req in READY restarts from RST_LO and clears stream_open.

Boundary conditions and timing:
- init_req while busy is ignored. stream_start while a pixel or RAMWR is in flight is ignored.
- Simultaneous stream_start and pix_valid in READY: stream_start wins and pix_ready=0 that cycle.
- tx_send is never asserted while spi_idle=0. At most one tx_send per byte.
- Latency: tx_send occurs 1 cycle after entering ISSUE when spi_idle is already high.
- Latency: the first init byte's tx_send occurs RST_LOW_CYC+RST_WAIT_CYC+2 cycles after init_req, ±1 for the FSM registering.
- Counters are sized for 255*DELAY_UNIT. The index never wraps: end stops it at 10.

Test Plan:
- SPI model at 8 cycles/byte. Pulse init_req, then check the following:
  - rst_ili stays low for 16 cycles.
  - The tx sequence is (dc,byte) = (0,01),(0,11),(0,3A),(1,55),(0,36),(1,48),(0,29).
  - Gaps after 0x01 and 0x11 are ≥160 and ≥3840 cycles.
  - init_done rises after the 10*32-cycle final delay.
- After init, pulse stream_start, then present pix_data=0xF81F with pix_valid. Required bytes: (0,2C),(1,F8),(1,1F), and pix_ready high exactly one cycle.
- Stall spi_idle low for 50 cycles while a byte is pending in ISSUE: no tx_send until spi_idle=1, and tx_byte/tx_dc stay stable during the transfer.
- Negative cases:
  - init_req asserted during DELAY: no restart, and the sequence is unchanged.
  - pix_valid before stream_start: pix_ready=0 and no tx_send.
- Assert rst during WAIT_DONE of byte 0x3A: all outputs return to reset values the next cycle.
  - A new init_req then replays the full sequence from 0x01.
- Back-to-back pixels 0x1234, 0xABCD with pix_valid held high: bytes 12,34,AB,CD all with dc=1, with two pix_ready pulses spaced by at least two SPI byte times.
